hx711_reader: RTL and testbench
===============================

# hx711_reader

Front-end stage that clocks 24-bit conversion results out of an HX711 load-cell ADC over its two-wire serial link (PD_SCK / DOUT) and presents each result as a parallel word with a one-cycle strobe. Its `dout`/`dataReady` pair feeds the byte serializer's `din`/`inputReady` directly, with `nofBytes=3` on that serializer. It also selects the ADC channel/gain for the next conversion through the trailing pulse count, and handles ADC power-down.

## Interface
- `CLK_DIV`, default 8: `pclk` cycles per PD_SCK half-period. Legal range 4..255.
- `GAIN_PULSES`, default 25: total PD_SCK pulses per frame.
  - 25 selects channel A, gain 128.
  - 26 selects channel B, gain 32.
  - 27 selects channel A, gain 64.
  - Any other value is illegal; elaboration fails.
- `pclk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  level; permits new frames to start.
- `pd`  in  1  level; requests ADC power-down.
- `adc_dout`  in  1  HX711 DOUT, asynchronous.
- `adc_sck`  out  1  HX711 PD_SCK, registered.
- `dout`  out  24  last complete conversion, raw two's complement, MSB = first bit received.
- `dataReady`  out  1  one-cycle strobe; `dout` is valid on that cycle and holds until the next strobe.
- `busy`  out  1  high from the first PD_SCK rising edge to the end of the final low phase.

## Operation
- `adc_dout` passes through a 2-flop synchronizer. All decisions use the synchronized value `sd`.
- States:
  - IDLE: `adc_sck`=0.
    - If `pd`=1, go to PWRDN.
    - Else if `en`=1 and `sd`=0, go to HIGH with pulse count = 0.
  - HIGH: `adc_sck`=1 for exactly `CLK_DIV` cycles.
    - On the last cycle, if pulse count < 24, shift `sd` into the 24-bit shift register, MSB first.
    - Then go to LOW.
  - LOW: `adc_sck`=0 for exactly `CLK_DIV` cycles. On the last cycle, increment the pulse count.
    - If count = `GAIN_PULSES`, go to DONE.
    - Otherwise go to HIGH.
  - DONE (1 cycle): copy the shift register to `dout`, pulse `dataReady`, go to RECOV.
  - RECOV: wait for `sd`=1, then go to IDLE. Prevents re-triggering on the stale DOUT low left from the frame just read.
  - PWRDN: `adc_sck`=1, held continuously.
    - When `pd`=0, drive `adc_sck`=0 and go to RECOV. The ADC resets and signals its next conversion with DOUT low.
- Mid-frame input changes:
  - `en` or `pd` asserted mid-frame does not abort the frame; the frame always completes. This keeps PD_SCK high for no more than `CLK_DIV` cycles.
  - `pd` is sampled only in IDLE.
  - `en` deasserted mid-frame still yields `dataReady` for that frame.
- Reset behaviour:
  - Reset values: `adc_sck`=0, `dout`=0, `dataReady`=0, `busy`=0, state IDLE, counters 0, synchronizer flops = 1.
  - Reset mid-frame discards the partial word, produces no `dataReady`, and drops `adc_sck` on the same edge.

## Timing
- Frame length, from the cycle IDLE sees `sd`=0 to the `dataReady` cycle:
  - 1 + 2·`CLK_DIV`·`GAIN_PULSES` + 1 cycles.
  - At defaults: 1 + 400 + 1 = 402 cycles.
- Sampling point: the bit is sampled `CLK_DIV`-1 cycles after the PD_SCK rise. With 2 cycles of synchronizer delay, `CLK_DIV` ≥ 4 ensures DOUT has settled.
- `dataReady` is high for exactly 1 cycle per completed frame and is never asserted twice without an intervening frame.
- `busy` drops on the DONE cycle.
- Outputs are registered; there is no combinational path from input to output.

## Structure
- Package `hx711_pkg` holds:
  - the state enum (IDLE, HIGH, LOW, DONE, RECOV, PWRDN);
  - `HX_BITS = 24`;
  - the gain constants `GAIN_A128 = 25`, `GAIN_B32 = 26`, `GAIN_A64 = 27`.
- Sub-module `sync2`: 2-flop synchronizer with a reset value parameter. Instantiated once for `adc_dout`.
- Top level contains:
  - the FSM;
  - the half-period counter (8 bits);
  - the pulse counter (5 bits);
  - the 24-bit shift register and the `dout` holding register.

## Test plan
- **Basic frame.** ADC model presents 24'hA5C3F0 with `GAIN_PULSES`=25, `CLK_DIV`=4 → exactly 25 PD_SCK pulses, each high for 4 cycles; `dout`=24'hA5C3F0 with a 1-cycle `dataReady` at cycle 202 after `sd` goes low.
- **Negative value and gain select.** ADC presents 24'h800001 with `GAIN_PULSES`=27 → `dout`=24'h800001; 27 pulses counted; the model reports gain 64 selected.
- **No re-trigger.** ADC holds DOUT low for 500 cycles after a frame → no second frame starts until DOUT has gone high and then low again; exactly one `dataReady`.
- **Reset mid-frame.** Assert `rst_n`=0 during pulse 10 → `adc_sck`=0 on the next edge; `dout` stays 0; no `dataReady`. A fresh frame after release captures correctly.
- **Power-down.** `pd`=1 in IDLE → `adc_sck` held at 1 for 10000 cycles. Release → `adc_sck`=0, then RECOV. The next frame captures correctly.
- **`pd`/`en` mid-frame.** Assert `pd`=1 and deassert `en` at pulse 5 → the frame completes with correct `dout` and `dataReady`, then enters PWRDN; `adc_sck` is never high for more than `CLK_DIV` consecutive cycles before that.

Source files
------------

// File: rtl/hx711_pkg.sv
// Shared definitions for the HX711 reader.
// Contents:
//   hx_state_e       frame sequencer states
//   HX_BITS          conversion word width
//   GAIN_A128/B32/A64  total PD_SCK pulses per frame selecting channel/gain
//   gain_legal()     true when a pulse count selects a real channel/gain
package hx711_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    DONE  = 3'd3,
    RECOV = 3'd4,
    PWRDN = 3'd5
  } hx_state_e;

  localparam int HX_BITS   = 24;
  localparam int GAIN_A128 = 25;
  localparam int GAIN_B32  = 26;
  localparam int GAIN_A64  = 27;

  function automatic bit gain_legal(input int pulses);
    return (pulses == GAIN_A128) || (pulses == GAIN_B32) || (pulses == GAIN_A64);
  endfunction

endpackage

// File: rtl/hx711_reader_sync.sv
// Two-flop synchronizer with a configurable reset value.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset, loads RST_VAL into both flops
//   d_i     asynchronous input
//   q_o     synchronized output (two clock cycles of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hx711_reader.sv
// HX711 load-cell ADC reader. Clocks a 24-bit conversion out over PD_SCK/DOUT,
// appends the trailing pulses that select the next channel/gain, and presents
// the result as a parallel word with a one-cycle strobe. Also drives ADC
// power-down by holding PD_SCK high.
// Ports:
//   pclk       sole clock, rising edge
//   rst_n      synchronous active-low reset
//   en         level, permits new frames to start
//   pd         level, requests ADC power-down (acted on only between frames)
//   adc_dout   HX711 DOUT, asynchronous
//   adc_sck    HX711 PD_SCK, registered
//   dout       last complete conversion, two's complement, MSB first received
//   dataReady  one-cycle strobe, dout valid on that cycle and held after
//   busy       high from first PD_SCK rise to end of the final low phase
//   state_o    current sequencer state (debug observation)
// Handshake: dataReady is a pure strobe with no back-pressure; the consumer
// must take dout on the strobe cycle or later, before the next strobe.
module hx711_reader
  import hx711_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int GAIN_PULSES = 25
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          pd,
  input  logic          adc_dout,
  output logic          adc_sck,
  output logic [23:0]   dout,
  output logic          dataReady,
  output logic          busy,
  output logic [2:0]    state_o
);

  if (!gain_legal(GAIN_PULSES)) begin : g_bad_gain
    $error("hx711_reader: GAIN_PULSES must be 25, 26 or 27");
  end
  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_div
    $error("hx711_reader: CLK_DIV must be in 4..255");
  end

  localparam logic [7:0] HALF_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] PULSE_END   = 5'(GAIN_PULSES);
  localparam logic [4:0] DATA_PULSES = 5'(HX_BITS);

  logic sd;

  // Reset value 1 so a reset never looks like "conversion ready".
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (pclk),
    .rst_ni (rst_n),
    .d_i    (adc_dout),
    .q_o    (sd)
  );

  hx_state_e            state_q, state_d;
  logic [7:0]           half_q, half_d;
  logic [4:0]           pulse_q, pulse_d;
  logic [HX_BITS-1:0]   shift_q, shift_d;
  logic [HX_BITS-1:0]   dout_q, dout_d;
  logic                 sck_q, sck_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic       last_half;
  logic [4:0] pulse_inc;

  assign last_half = (half_q == HALF_LAST);
  assign pulse_inc = pulse_q + 5'd1;

  // State and datapath registers.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      pulse_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      sck_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      pulse_q <= pulse_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      sck_q   <= sck_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Once a frame starts it always runs to DONE so PD_SCK is
  // never held high long enough to power the ADC down by accident.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pd)             state_d = PWRDN;
        else if (en && !sd) state_d = HIGH;
      end
      HIGH: begin
        if (last_half) state_d = LOW;
      end
      LOW: begin
        if (last_half) state_d = (pulse_inc == PULSE_END) ? DONE : HIGH;
      end
      DONE:  state_d = RECOV;
      // DOUT stays low after readout until the ADC starts the next
      // conversion; wait for it to go high so the same frame is not re-read.
      RECOV: begin
        if (sd) state_d = IDLE;
      end
      PWRDN: begin
        if (!pd) state_d = RECOV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Outputs are registered from state_d so
  // they line up with the state they belong to.
  always_comb begin
    half_d  = '0;
    pulse_d = pulse_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;

    if ((state_q == HIGH || state_q == LOW) && !last_half) half_d = half_q + 8'd1;

    if (state_q == IDLE)                   pulse_d = '0;
    else if (state_q == LOW && last_half)  pulse_d = pulse_inc;

    // Sample late in the high phase; DOUT changes just after the PD_SCK rise.
    if (state_q == HIGH && last_half && pulse_q < DATA_PULSES)
      shift_d = {shift_q[HX_BITS-2:0], sd};

    if (state_d == DONE) begin
      dout_d = shift_q;
      rdy_d  = 1'b1;
    end

    sck_d  = (state_d == HIGH) || (state_d == PWRDN);
    busy_d = (state_d == HIGH) || (state_d == LOW);
  end

  assign adc_sck   = sck_q;
  assign dout      = dout_q;
  assign dataReady = rdy_q;
  assign busy      = busy_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hx711_reader.sv
// Bench for hx711_reader. Two instances share clock and reset: index 0 uses
// 25 trailing pulses (channel A, gain 128), index 1 uses 27 (channel A, gain 64).
// Each has a small HX711 model that drives DOUT low when a conversion is
// requested and shifts the word out MSB first on PD_SCK rising edges.
module tb_hx711_reader;

  localparam int CLK_DIV = 4;
  localparam int GP_A    = 25;
  localparam int GP_B    = 27;
  // Edges from the model pulling DOUT low to the strobe sample:
  // 2 synchronizer + 1 IDLE cycle + all high/low phases.
  localparam int LAT_A   = 3 + 2 * CLK_DIV * GP_A;
  localparam int LAT_B   = 3 + 2 * CLK_DIV * GP_B;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst_n = 1'b0;
  logic        en_a = 1'b1, pd_a = 1'b0, en_b = 1'b1, pd_b = 1'b0;
  logic [1:0]  adc_dout = 2'b11;
  logic [1:0]  sck;
  logic [1:0]  rdy;
  logic [1:0]  busy;
  logic [23:0] dout_a, dout_b;
  logic [2:0]  state_a, state_b;

  hx711_reader #(.CLK_DIV(CLK_DIV), .GAIN_PULSES(GP_A)) dut_a (
    .pclk(pclk), .rst_n(rst_n), .en(en_a), .pd(pd_a), .adc_dout(adc_dout[0]),
    .adc_sck(sck[0]), .dout(dout_a), .dataReady(rdy[0]), .busy(busy[0]),
    .state_o(state_a)
  );

  hx711_reader #(.CLK_DIV(CLK_DIV), .GAIN_PULSES(GP_B)) dut_b (
    .pclk(pclk), .rst_n(rst_n), .en(en_b), .pd(pd_b), .adc_dout(adc_dout[1]),
    .adc_sck(sck[1]), .dout(dout_b), .dataReady(rdy[1]), .busy(busy[1]),
    .state_o(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_qa[$];
  logic [23:0] exp_qb[$];
  int checks = 0;
  int errors = 0;

  // ---------------- ADC model ----------------
  logic [23:0] req_word [2];
  int          req_seq [2]   = '{0, 0};
  int          abort_seq [2] = '{0, 0};
  logic [1:0]  hold_low      = 2'b00;

  int          seen_req [2]   = '{0, 0};
  int          seen_abort [2] = '{0, 0};
  logic [23:0] word_cur [2];
  int          cnt [2]        = '{0, 0};
  logic [1:0]  active         = 2'b00;
  logic [1:0]  sck_prev       = 2'b00;
  int          start_cyc [2]  = '{0, 0};
  int          cyc            = 0;

  always @(posedge pclk) begin
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (abort_seq[k] != seen_abort[k]) begin
        seen_abort[k] = abort_seq[k];
        active[k]     = 1'b0;
        adc_dout[k]   = 1'b1;
      end else if (req_seq[k] != seen_req[k]) begin
        seen_req[k]  = req_seq[k];
        word_cur[k]  = req_word[k];
        cnt[k]       = 0;
        active[k]    = 1'b1;
        adc_dout[k]  = 1'b0;
        start_cyc[k] = cyc;
      end else begin
        if (sck[k] && !sck_prev[k]) cnt[k]++;
        if (active[k]) begin
          if (cnt[k] >= 1 && cnt[k] <= 24) adc_dout[k] = word_cur[k][24 - cnt[k]];
          else if (cnt[k] >= 25)            adc_dout[k] = !hold_low[k];
        end
      end
      sck_prev[k] = sck[k];
    end
  end

  // Longest PD_SCK high run since the last clear request.
  int clr_seq [2]  = '{0, 0};
  int seen_clr [2] = '{0, 0};
  int run [2]      = '{0, 0};
  int max_run [2]  = '{0, 0};

  always @(negedge pclk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_seq[k] != seen_clr[k]) begin
        seen_clr[k] = clr_seq[k];
        run[k]      = 0;
        max_run[k]  = 0;
      end
      if (sck[k]) run[k]++;
      else        run[k] = 0;
      if (run[k] > max_run[k]) max_run[k] = run[k];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic start_conv(input int k, input logic [23:0] w);
    @(negedge pclk);
    req_word[k] = w;
    req_seq[k]++;
    if (k == 0) exp_qa.push_back(w);
    else        exp_qb.push_back(w);
  endtask

  task automatic wait_rdy(input int k, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge pclk);
      if (rdy[k]) got = 1'b1;
    end
  endtask

  task automatic wait_pulse(input int k, input int n, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge pclk);
      if (cnt[k] == n && sck[k]) got = 1'b1;
    end
  endtask

  function automatic logic [23:0] pop_exp(input int k);
    if (k == 0) return (exp_qa.size() > 0) ? exp_qa.pop_front() : 24'hxxxxxx;
    else        return (exp_qb.size() > 0) ? exp_qb.pop_front() : 24'hxxxxxx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cycles(4);
    checks++;
    if (sck !== 2'b00) begin errors++; $display("FAIL reset_sck got %b want 00", sck); end
    checks++;
    if (dout_a !== 24'h0 || dout_b !== 24'h0) begin
      errors++; $display("FAIL reset_dout got %h/%h want 000000", dout_a, dout_b);
    end
    checks++;
    if (rdy !== 2'b00 || busy !== 2'b00) begin
      errors++; $display("FAIL reset_flags rdy %b busy %b want 00/00", rdy, busy);
    end
    rst_n = 1'b1;
    cycles(5);
    checks++;
    if (sck !== 2'b00 || rdy !== 2'b00) begin
      errors++; $display("FAIL reset_idle sck %b rdy %b want 00/00", sck, rdy);
    end
  endtask

  task automatic test_basic_frame();
    bit got;
    logic [23:0] exp;
    clr_seq[0]++;
    start_conv(0, 24'hA5C3F0);
    wait_rdy(0, LAT_A + 20, got);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_timeout no dataReady"); exp = pop_exp(0); end
    else begin
      exp = pop_exp(0);
      checks++;
      if (dout_a !== exp) begin errors++; $display("FAIL basic_dout got %h want %h", dout_a, exp); end
      checks++;
      if (cyc - start_cyc[0] != LAT_A) begin
        errors++; $display("FAIL basic_latency got %0d want %0d", cyc - start_cyc[0], LAT_A);
      end
      checks++;
      if (cnt[0] != GP_A) begin errors++; $display("FAIL basic_pulses got %0d want %0d", cnt[0], GP_A); end
      checks++;
      if (max_run[0] != CLK_DIV) begin
        errors++; $display("FAIL basic_high_width got %0d want %0d", max_run[0], CLK_DIV);
      end
      checks++;
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy[0]); end
      @(negedge pclk);
      checks++;
      if (rdy[0] !== 1'b0 || dout_a !== exp) begin
        errors++; $display("FAIL basic_strobe_width rdy %b dout %h want 0/%h", rdy[0], dout_a, exp);
      end
    end
    cycles(5);
  endtask

  task automatic test_gain_select();
    bit got;
    logic [23:0] exp;
    start_conv(1, 24'h800001);
    wait_rdy(1, LAT_B + 20, got);
    checks++;
    if (!got) begin errors++; $display("FAIL gain_timeout no dataReady"); exp = pop_exp(1); end
    else begin
      exp = pop_exp(1);
      checks++;
      if (dout_b !== exp) begin errors++; $display("FAIL gain_dout got %h want %h", dout_b, exp); end
      checks++;
      if (cnt[1] != GP_B) begin errors++; $display("FAIL gain_a64_pulses got %0d want %0d", cnt[1], GP_B); end
      checks++;
      if (cyc - start_cyc[1] != LAT_B) begin
        errors++; $display("FAIL gain_latency got %0d want %0d", cyc - start_cyc[1], LAT_B);
      end
    end
    cycles(5);
  endtask

  task automatic test_no_retrigger();
    bit got;
    int highs, extra;
    logic [23:0] w, exp;
    hold_low[0] = 1'b1;
    w = 24'($urandom_range(0, 24'hFFFFFF));
    start_conv(0, w);
    wait_rdy(0, LAT_A + 20, got);
    exp = pop_exp(0);
    checks++;
    if (!got || dout_a !== exp) begin
      errors++; $display("FAIL noretrig_first got %h rdy %b want %h", dout_a, got, exp);
    end
    highs = 0; extra = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge pclk);
      if (sck[0]) highs++;
      if (rdy[0]) extra++;
    end
    checks++;
    if (highs != 0 || extra != 0) begin
      errors++; $display("FAIL noretrig_hold sck_high %0d strobes %0d want 0/0", highs, extra);
    end
    hold_low[0] = 1'b0;
    cycles(6);
    w = 24'($urandom_range(0, 24'hFFFFFF));
    start_conv(0, w);
    wait_rdy(0, LAT_A + 20, got);
    exp = pop_exp(0);
    checks++;
    if (!got || dout_a !== exp) begin
      errors++; $display("FAIL noretrig_second got %h rdy %b want %h", dout_a, got, exp);
    end
    cycles(5);
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    int extra;
    logic [23:0] w, exp;
    start_conv(0, 24'h3C96E1);
    wait_pulse(0, 10, LAT_A, got);
    checks++;
    if (!got) begin errors++; $display("FAIL rstmid_pulse10 never reached"); end
    rst_n = 1'b0;
    abort_seq[0]++;
    exp_qa.delete();
    @(posedge pclk); #1;
    checks++;
    if (sck[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_sck_drop sck %b rdy %b want 0/0", sck[0], rdy[0]);
    end
    cycles(4);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (rdy[0]) extra++;
    end
    checks++;
    if (extra != 0 || dout_a !== 24'h0) begin
      errors++; $display("FAIL rstmid_discard strobes %0d dout %h want 0/000000", extra, dout_a);
    end
    w = 24'($urandom_range(0, 24'hFFFFFF));
    start_conv(0, w);
    wait_rdy(0, LAT_A + 20, got);
    exp = pop_exp(0);
    checks++;
    if (!got || dout_a !== exp) begin
      errors++; $display("FAIL rstmid_fresh got %h rdy %b want %h", dout_a, got, exp);
    end
    cycles(5);
  endtask

  task automatic test_power_down();
    bit got;
    int lows;
    logic [23:0] exp;
    pd_a = 1'b1;
    cycles(3);
    lows = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge pclk);
      if (!sck[0]) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL pwrdn_hold sck low cycles %0d want 0", lows); end
    @(negedge pclk);
    pd_a = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (sck[0] !== 1'b0) begin errors++; $display("FAIL pwrdn_release sck %b want 0", sck[0]); end
    cycles(4);
    start_conv(0, 24'h7FFFFF);
    wait_rdy(0, LAT_A + 20, got);
    exp = pop_exp(0);
    checks++;
    if (!got || dout_a !== exp) begin
      errors++; $display("FAIL pwrdn_next_frame got %h rdy %b want %h", dout_a, got, exp);
    end
    cycles(5);
  endtask

  task automatic test_pd_en_mid_frame();
    bit got;
    logic [23:0] exp;
    clr_seq[0]++;
    start_conv(0, 24'h0F1E2D);
    wait_pulse(0, 5, LAT_A, got);
    pd_a = 1'b1;
    en_a = 1'b0;
    wait_rdy(0, LAT_A + 20, got);
    exp = pop_exp(0);
    checks++;
    if (!got || dout_a !== exp) begin
      errors++; $display("FAIL pden_frame got %h rdy %b want %h", dout_a, got, exp);
    end
    checks++;
    if (max_run[0] != CLK_DIV) begin
      errors++; $display("FAIL pden_high_width got %0d want %0d", max_run[0], CLK_DIV);
    end
    cycles(12);
    checks++;
    if (sck[0] !== 1'b1) begin errors++; $display("FAIL pden_enter_pwrdn sck %b want 1", sck[0]); end
    pd_a = 1'b0;
    en_a = 1'b1;
    cycles(3);
    checks++;
    if (sck[0] !== 1'b0) begin errors++; $display("FAIL pden_release sck %b want 0", sck[0]); end
    cycles(5);
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [23:0] w, exp;
    for (int n = 0; n < 3; n++) begin
      w = 24'($urandom_range(0, 24'hFFFFFF));
      start_conv(1, w);
      wait_rdy(1, LAT_B + 20, got);
      exp = pop_exp(1);
      checks++;
      if (!got || dout_b !== exp) begin
        errors++; $display("FAIL b2b_frame%0d got %h rdy %b want %h", n, dout_b, got, exp);
      end
      cycles(4);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gain_select();
    test_no_retrigger();
    test_reset_mid_frame();
    test_power_down();
    test_pd_en_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
